clock_rand_scan_master: RTL and testbench

CLOCK_RAND_SCAN_MASTER -- requirements
Module: clock_rand_scan_master

---
 rtl/clock_rand_scan_master_if.sv | 38 +++
 rtl/clock_rand_scan_master.sv | 156 +++++++++++++++
 tb/tb_clock_rand_scan_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_rand_scan_master_if.sv
// Handshake and serial-chain bundle for clock_rand_scan_master.
// master modport: the scan master (drives o_*, samples i_*).
// slave modport : requester / readback consumer / chain side (drives i_*).
// Signals:
//   i_wr_valid/o_wr_ready/i_wr_data     - scan request handshake and word
//   i_abort                             - synchronous abort
//   o_ser_valid/o_ser_data/i_ser_ret    - serial chain shift enable, out and return bit
//   o_rd_valid/i_rd_ready/o_rd_data     - readback handshake and captured word
//   o_rd_parity                         - even parity of o_rd_data
//   o_busy                              - block not idle
interface clock_rand_scan_master_if #(
    parameter int unsigned CHAIN_LEN = 8
) ();
    logic                 i_wr_valid;
    logic                 o_wr_ready;
    logic [CHAIN_LEN-1:0] i_wr_data;
    logic                 i_abort;
    logic                 o_ser_valid;
    logic                 o_ser_data;
    logic                 i_ser_ret;
    logic                 o_rd_valid;
    logic                 i_rd_ready;
    logic [CHAIN_LEN-1:0] o_rd_data;
    logic                 o_rd_parity;
    logic                 o_busy;

    modport master (
        input  i_wr_valid, i_wr_data, i_abort, i_ser_ret, i_rd_ready,
        output o_wr_ready, o_ser_valid, o_ser_data, o_rd_valid, o_rd_data,
               o_rd_parity, o_busy
    );

    modport slave (
        output i_wr_valid, i_wr_data, i_abort, i_ser_ret, i_rd_ready,
        input  o_wr_ready, o_ser_valid, o_ser_data, o_rd_valid, o_rd_data,
               o_rd_parity, o_busy
    );
endinterface

// File: rtl/clock_rand_scan_master.sv
// Scan chain master: accepts a CHAIN_LEN-bit word, shifts it LSB first into
// an external chain while capturing the chain's prior contents from its
// return bit, then presents the captured word on a ready/valid readback port.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - clock_rand_scan_master_if.master (request, serial chain, readback)
// Optional feature: define SCAN_READBACK_PARITY_EN to generate o_rd_parity
// (XOR of the captured word); otherwise o_rd_parity is tied to 0.
module clock_rand_scan_master #(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    clock_rand_scan_master_if.master   bus
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic [CHAIN_LEN-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ser_valid_q, ser_valid_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 wr_ready_q;
    logic                 busy_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        ser_valid_d = ser_valid_q;
        rd_valid_d  = rd_valid_q;

        case (state_q)
            ST_IDLE: begin
                // Abort is deliberately ignored here so a simultaneous request wins
                if (bus.i_wr_valid) begin
                    state_d     = ST_SHIFT;
                    shreg_d     = bus.i_wr_data;
                    cap_d       = '0;
                    cnt_d       = '0;
                    ser_valid_d = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (bus.i_abort) begin
                    state_d     = ST_IDLE;
                    ser_valid_d = 1'b0;
                    shreg_d     = '0;
                    cap_d       = '0;
                    cnt_d       = '0;
                end else begin
                    // Return bit enters MSB-side; first sample ends up at bit 0
                    cap_d   = {bus.i_ser_ret, cap_q[CHAIN_LEN-1:1]};
                    shreg_d = {1'b0, shreg_q[CHAIN_LEN-1:1]};
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d     = ST_DONE;
                        ser_valid_d = 1'b0;
                        rd_valid_d  = 1'b1;
                        rd_data_d   = cap_d;
                        cnt_d       = CNT_W'(CHAIN_LEN);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (bus.i_abort) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                    cap_d      = '0;
                end else if (bus.i_rd_ready) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                ser_valid_d = 1'b0;
                rd_valid_d  = 1'b0;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            cap_q       <= '0;
            rd_data_q   <= '0;
            cnt_q       <= '0;
            ser_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cap_q       <= cap_d;
            rd_data_q   <= rd_data_d;
            cnt_q       <= cnt_d;
            ser_valid_q <= ser_valid_d;
            rd_valid_q  <= rd_valid_d;
            wr_ready_q  <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign bus.o_wr_ready  = wr_ready_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_ser_valid = ser_valid_q;
    // Shift register bit 0 is itself a flop, so serial data is registered
    assign bus.o_ser_data  = shreg_q[0];
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_rd_data   = rd_data_q;

`ifdef SCAN_READBACK_PARITY_EN
    logic parity_q;

    // Parity updates together with o_rd_data on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if ((state_q == ST_SHIFT) && (state_d == ST_DONE)) begin
            parity_q <= ^rd_data_d;
        end
    end

    assign bus.o_rd_parity = parity_q;
`else
    assign bus.o_rd_parity = 1'b0;
`endif

endmodule

// File: tb/tb_clock_rand_scan_master.sv
// Self-checking bench for clock_rand_scan_master with a behavioural scan
// chain model (shift right on o_ser_valid, o_ser_data into MSB, bit 0 returned).
module tb_clock_rand_scan_master;
    localparam int unsigned N = 8;

`ifdef SCAN_READBACK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    clock_rand_scan_master_if #(.CHAIN_LEN(N)) sif ();

    clock_rand_scan_master #(.CHAIN_LEN(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.master)
    );

    int checks = 0;
    int errors = 0;

    // Chain model
    logic [N-1:0] chain;
    logic         preload_en;
    logic [N-1:0] preload_val;

    always @(posedge clk) begin
        if (preload_en) begin
            chain <= preload_val;
        end else if (sif.o_ser_valid) begin
            chain <= {sif.o_ser_data, chain[N-1:1]};
        end
    end

    assign sif.i_ser_ret = chain[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Preload chain, issue request, check the full N-cycle burst; ends sampling in DONE
    task automatic do_shift(input logic [N-1:0] pre, input logic [N-1:0] w);
        preload_en  = 1'b1;
        preload_val = pre;
        step();
        preload_en     = 1'b0;
        sif.i_wr_valid = 1'b1;
        sif.i_wr_data  = w;
        check("accept_ready", 32'(sif.o_wr_ready), 32'd1);
        step();
        sif.i_wr_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            check("burst_valid", 32'(sif.o_ser_valid), 32'd1);
            check("burst_data", 32'(sif.o_ser_data), 32'(w[i]));
            step();
        end
        check("burst_end", 32'(sif.o_ser_valid), 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] preload;
        logic [N-1:0] wdata;
        logic [N-1:0] exp_rd;
        logic         exp_par;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{preload: 8'h3C, wdata: 8'hA5, exp_rd: 8'h3C, exp_par: 1'b0};
        vecs[1] = '{preload: 8'h07, wdata: 8'h00, exp_rd: 8'h07, exp_par: 1'b1};
        vecs[2] = '{preload: 8'hFF, wdata: 8'h12, exp_rd: 8'hFF, exp_par: 1'b0};
        vecs[3] = '{preload: 8'h80, wdata: 8'hFF, exp_rd: 8'h80, exp_par: 1'b1};
        vecs[4] = '{preload: 8'h55, wdata: 8'h3C, exp_rd: 8'h55, exp_par: 1'b0};

        rst_n          = 1'b0;
        sif.i_wr_valid = 1'b0;
        sif.i_wr_data  = '0;
        sif.i_abort    = 1'b0;
        sif.i_rd_ready = 1'b0;
        preload_en     = 1'b0;
        preload_val    = '0;
        step();
        step();

        // Reset state
        check("rst_ser_valid", 32'(sif.o_ser_valid), 32'd0);
        check("rst_ser_data", 32'(sif.o_ser_data), 32'd0);
        check("rst_rd_valid", 32'(sif.o_rd_valid), 32'd0);
        check("rst_rd_data", 32'(sif.o_rd_data), 32'd0);
        check("rst_parity", 32'(sif.o_rd_parity), 32'd0);
        check("rst_busy", 32'(sif.o_busy), 32'd0);
        check("rst_wr_ready", 32'(sif.o_wr_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Table-driven full transactions
        for (int v = 0; v < 5; v++) begin
            do_shift(vecs[v].preload, vecs[v].wdata);
            check("vec_rd_valid", 32'(sif.o_rd_valid), 32'd1);
            check("vec_rd_data", 32'(sif.o_rd_data), 32'(vecs[v].exp_rd));
            check("vec_parity", 32'(sif.o_rd_parity), 32'(PAR_EN ? vecs[v].exp_par : 1'b0));
            check("vec_busy", 32'(sif.o_busy), 32'd1);
            check("vec_wr_ready", 32'(sif.o_wr_ready), 32'd0);
            sif.i_rd_ready = 1'b1;
            step();
            sif.i_rd_ready = 1'b0;
            check("vec_chain", 32'(chain), 32'(vecs[v].wdata));
            check("vec_rd_drop", 32'(sif.o_rd_valid), 32'd0);
            check("vec_idle_ready", 32'(sif.o_wr_ready), 32'd1);
            check("vec_idle_busy", 32'(sif.o_busy), 32'd0);
        end

        // Back-to-back with rd_ready held high
        begin
            int accepts = 0;
            int runs = 0;
            int len0 = 0;
            int len1 = 0;
            int idle_between = 0;
            int n_rd = 0;
            logic prev_sv = 1'b0;
            logic [N-1:0] rd0 = '0;
            logic [N-1:0] rd1 = '0;
            preload_en  = 1'b1;
            preload_val = 8'h00;
            step();
            preload_en     = 1'b0;
            sif.i_rd_ready = 1'b1;
            sif.i_wr_valid = 1'b1;
            sif.i_wr_data  = 8'h5A;
            for (int c = 0; c < 26; c++) begin
                logic acc;
                acc = sif.i_wr_valid && sif.o_wr_ready;
                if (sif.o_ser_valid && !prev_sv) runs++;
                if (sif.o_ser_valid && runs == 1) len0++;
                if (sif.o_ser_valid && runs == 2) len1++;
                if (runs == 1 && !sif.o_ser_valid && sif.o_wr_ready) idle_between++;
                if (sif.o_rd_valid) begin
                    if (n_rd == 0) rd0 = sif.o_rd_data;
                    else rd1 = sif.o_rd_data;
                    n_rd++;
                end
                prev_sv = sif.o_ser_valid;
                step();
                if (acc) begin
                    accepts++;
                    if (accepts == 1) sif.i_wr_data = 8'hFF;
                    else sif.i_wr_valid = 1'b0;
                end
            end
            sif.i_rd_ready = 1'b0;
            check("b2b_accepts", 32'(accepts), 32'd2);
            check("b2b_runs", 32'(runs), 32'd2);
            check("b2b_len0", 32'(len0), 32'(N));
            check("b2b_len1", 32'(len1), 32'(N));
            check("b2b_idle_between", 32'(idle_between), 32'd1);
            check("b2b_n_rd", 32'(n_rd), 32'd2);
            check("b2b_rd0", 32'(rd0), 32'h00);
            check("b2b_rd1", 32'(rd1), 32'h5A);
            check("b2b_chain", 32'(chain), 32'hFF);
        end

        // Backpressure in DONE with a pending request
        do_shift(8'hC3, 8'h11);
        sif.i_wr_valid = 1'b1;
        sif.i_wr_data  = 8'h22;
        for (int c = 0; c < 5; c++) begin
            check("bp_rd_valid", 32'(sif.o_rd_valid), 32'd1);
            check("bp_rd_data", 32'(sif.o_rd_data), 32'hC3);
            check("bp_wr_ready", 32'(sif.o_wr_ready), 32'd0);
            check("bp_ser_valid", 32'(sif.o_ser_valid), 32'd0);
            step();
        end
        sif.i_rd_ready = 1'b1;
        step();
        sif.i_rd_ready = 1'b0;
        check("bp_idle_ready", 32'(sif.o_wr_ready), 32'd1);
        check("bp_not_yet", 32'(sif.o_ser_valid), 32'd0);
        step();
        sif.i_wr_valid = 1'b0;
        check("bp_accepted", 32'(sif.o_ser_valid), 32'd1);
        for (int c = 0; c < int'(N); c++) step();
        check("bp2_rd_valid", 32'(sif.o_rd_valid), 32'd1);
        check("bp2_rd_data", 32'(sif.o_rd_data), 32'h11);
        sif.i_rd_ready = 1'b1;
        step();
        sif.i_rd_ready = 1'b0;

        // Abort on shift cycle 3
        preload_en  = 1'b1;
        preload_val = 8'hE7;
        step();
        preload_en     = 1'b0;
        sif.i_wr_valid = 1'b1;
        sif.i_wr_data  = 8'h96;
        step();
        sif.i_wr_valid = 1'b0;
        step();
        step();
        check("ab_cycle3_valid", 32'(sif.o_ser_valid), 32'd1);
        sif.i_abort = 1'b1;
        step();
        sif.i_abort = 1'b0;
        check("ab_ser_valid", 32'(sif.o_ser_valid), 32'd0);
        check("ab_rd_valid", 32'(sif.o_rd_valid), 32'd0);
        check("ab_wr_ready", 32'(sif.o_wr_ready), 32'd1);
        check("ab_busy", 32'(sif.o_busy), 32'd0);
        begin
            int rd_seen = 0;
            for (int c = 0; c < 12; c++) begin
                if (sif.o_rd_valid || sif.o_ser_valid) rd_seen++;
                step();
            end
            check("ab_no_pulse", 32'(rd_seen), 32'd0);
        end

        // Abort with request in IDLE: request wins; then abort in DONE
        preload_en  = 1'b1;
        preload_val = 8'h0F;
        step();
        preload_en     = 1'b0;
        sif.i_wr_valid = 1'b1;
        sif.i_abort    = 1'b1;
        sif.i_wr_data  = 8'hF0;
        step();
        sif.i_wr_valid = 1'b0;
        sif.i_abort    = 1'b0;
        check("abidle_accept", 32'(sif.o_ser_valid), 32'd1);
        for (int c = 0; c < int'(N); c++) step();
        check("abdone_rd_valid", 32'(sif.o_rd_valid), 32'd1);
        sif.i_abort = 1'b1;
        step();
        sif.i_abort = 1'b0;
        check("abdone_rd_drop", 32'(sif.o_rd_valid), 32'd0);
        check("abdone_wr_ready", 32'(sif.o_wr_ready), 32'd1);

        // Reset asserted on shift cycle 5
        preload_en  = 1'b1;
        preload_val = 8'h99;
        step();
        preload_en     = 1'b0;
        sif.i_wr_valid = 1'b1;
        sif.i_wr_data  = 8'hC6;
        step();
        sif.i_wr_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("mr_cycle5_valid", 32'(sif.o_ser_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_ser_valid", 32'(sif.o_ser_valid), 32'd0);
        check("mr_ser_data", 32'(sif.o_ser_data), 32'd0);
        check("mr_rd_valid", 32'(sif.o_rd_valid), 32'd0);
        check("mr_rd_data", 32'(sif.o_rd_data), 32'd0);
        check("mr_parity", 32'(sif.o_rd_parity), 32'd0);
        check("mr_busy", 32'(sif.o_busy), 32'd0);
        check("mr_wr_ready", 32'(sif.o_wr_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        do_shift(8'h07, 8'h01);
        check("mr_rd_data_after", 32'(sif.o_rd_data), 32'h07);
        check("mr_parity_after", 32'(sif.o_rd_parity), 32'(PAR_EN ? 1'b1 : 1'b0));
        sif.i_rd_ready = 1'b1;
        step();
        sif.i_rd_ready = 1'b0;
        check("mr_chain_after", 32'(chain), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
